// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Provides the FSM state encoding, default vectors and the PC increment.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/pc_sequencer_adder.sv
// 32-bit two-input adder, modulo 2^32, no carry out.
// Ports: i_a, i_b operands; o_sum = i_a + i_b.
module pc_sequencer_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC selection and boot/stall/halt FSM.
// Ports: clk, reset (async high), control inputs; pc, pc_plus4, pc_valid, epc, addr_err, state.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic [31:0] epc,
  output logic        addr_err,
  output logic [1:0]  state
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_addr_err;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_off_sh;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_next_pc;
  logic        w_jr_bad;

  // Offset is in words; bits shifted past bit 31 are dropped.
  assign w_off_sh = branch_offset << 2;

  pc_sequencer_adder u_inc (
    .i_a   (r_pc),
    .i_b   (PC_INC),
    .o_sum (w_pc_plus4)
  );

  pc_sequencer_adder u_br (
    .i_a   (w_pc_plus4),
    .i_b   (w_off_sh),
    .o_sum (w_branch_tgt)
  );

  assign w_jump_tgt = {w_pc_plus4[31:28], jump_index, 2'b00};
  assign w_jr_bad   = jr && (jr_target[1:0] != 2'b00);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)
      w_next_pc = jr_target;
    else if (jump)
      w_next_pc = w_jump_tgt;
    else if (branch_taken)
      w_next_pc = w_branch_tgt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_epc      <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      unique case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (exception) begin
            r_pc  <= EXC_VECTOR;
            r_epc <= r_pc;
          end else if (halt_req) begin
            r_state <= HALT;
          end else if (stall) begin
            r_state <= STALL;
          end else if (w_jr_bad) begin
            r_pc       <= EXC_VECTOR;
            r_epc      <= r_pc;
            r_addr_err <= 1'b1;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        STALL: begin
          if (exception) begin
            r_pc    <= EXC_VECTOR;
            r_epc   <= r_pc;
            r_state <= RUN;
          end else if (!stall) begin
            r_state <= RUN;
          end
        end
        HALT: begin
          // Resume cycle does not fetch; held pc is fetched next.
          if (resume)
            r_state <= RUN;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign pc_valid = (r_state == RUN);
  assign epc      = r_epc;
  assign addr_err = r_addr_err;
  assign state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Drives hand-built vectors and compares against hand-computed values.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic [31:0] epc;
  logic        addr_err;
  logic [1:0]  state;

  int n_chk;
  int n_err;

  localparam logic [31:0] EXC = 32'h8000_0180;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .exception     (exception),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .epc           (epc),
    .addr_err      (addr_err),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'd0;
    jump          = 1'b0;
    jump_index    = 26'd0;
    jr            = 1'b0;
    jr_target     = 32'd0;
    exception     = 1'b0;
    halt_req      = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] t);
    idle();
    jr        = 1'b1;
    jr_target = t;
    step();
    idle();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_epc", epc, 32'h0);
    check("rst_aerr", {31'd0, addr_err}, 32'd0);
    step();
    step();
    reset = 1'b0;
    check("boot_state", {30'd0, state}, 32'd0);
    jump       = 1'b1;
    jump_index = 26'h40;
    step();
    idle();
    check("boot_exit_state", {30'd0, state}, 32'd1);
    check("first_fetch", pc, 32'h0);
    check("first_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check("seq_4", pc, 32'h4);
    step();
    check("seq_8", pc, 32'h8);
    step();
    check("seq_c", pc, 32'hC);
    step();
    check("seq_10", pc, 32'h10);

    branch_taken  = 1'b1;
    branch_offset = 32'hFFFF_FFFE;
    step();
    idle();
    check("branch_back", pc, 32'hC);
    step();
    check("seq_10b", pc, 32'h10);
    jump          = 1'b1;
    jump_index    = 26'h40;
    branch_taken  = 1'b1;
    branch_offset = 32'hFFFF_FFFE;
    step();
    idle();
    check("jump_wins", pc, 32'h100);

    jr_to(32'h20);
    check("jr_20", pc, 32'h20);
    jr        = 1'b1;
    jr_target = 32'h0040_0002;
    step();
    check("jr_bad_pc", pc, EXC);
    check("jr_bad_epc", epc, 32'h20);
    check("jr_bad_aerr", {31'd0, addr_err}, 32'd1);
    jr_target = 32'h0040_0000;
    step();
    idle();
    check("jr_ok_pc", pc, 32'h0040_0000);
    check("jr_ok_aerr", {31'd0, addr_err}, 32'd0);
    check("jr_ok_epc", epc, 32'h20);

    jr_to(32'h40);
    check("pc_40", pc, 32'h40);
    stall = 1'b1;
    step();
    check("stall1_pc", pc, 32'h40);
    check("stall1_state", {30'd0, state}, 32'd2);
    check("stall1_valid", {31'd0, pc_valid}, 32'd0);
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    check("stall2_pc", pc, 32'h40);
    check("stall2_state", {30'd0, state}, 32'd2);
    exception = 1'b1;
    step();
    idle();
    check("stall_exc_pc", pc, EXC);
    check("stall_exc_epc", epc, 32'h40);
    check("stall_exc_state", {30'd0, state}, 32'd1);

    jr_to(32'h80);
    check("pc_80", pc, 32'h80);
    halt_req = 1'b1;
    stall    = 1'b1;
    step();
    halt_req  = 1'b0;
    exception = 1'b1;
    check("halt_state", {30'd0, state}, 32'd3);
    check("halt_pc", pc, 32'h80);
    check("halt_valid", {31'd0, pc_valid}, 32'd0);
    step();
    idle();
    check("halt_hold_state", {30'd0, state}, 32'd3);
    check("halt_hold_pc", pc, 32'h80);
    check("halt_hold_epc", epc, 32'h40);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_state", {30'd0, state}, 32'd1);
    check("resume_pc", pc, 32'h80);
    check("resume_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check("resume_next", pc, 32'h84);

    jr_to(32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_plus4", pc_plus4, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);
    step();
    check("wrap_next", pc, 32'h4);
    stall = 1'b1;
    step();
    halt_req = 1'b1;
    step();
    check("stall_nohalt_state", {30'd0, state}, 32'd2);
    check("stall_nohalt_pc", pc, 32'h4);
    #3;
    reset = 1'b1;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_state", {30'd0, state}, 32'd0);
    check("async_epc", epc, 32'h0);
    check("async_valid", {31'd0, pc_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the MIPS single-cycle core. It owns the PC register and sequences the 32-bit adders that produce PC+4 and the branch target. It selects the next PC from sequential, branch, jump, jump-register and exception sources. A small FSM handles boot, stall and halt/resume.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and used on the first fetch.
EXC_VECTOR, 32'h8000_0180, PC loaded on an exception or a misaligned jr.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold the PC this cycle (hazard or memory wait).
branch_taken  in  1  conditional branch resolved as taken.
branch_offset  in  32  sign-extended immediate, in words.
jump  in  1  j/jal.
jump_index  in  26  instr[25:0].
jr  in  1  jr/jalr.
jr_target  in  32  rs value.
exception  in  1  synchronous exception request from the datapath.
halt_req  in  1  enter HALT (e.g. syscall/debug).
resume  in  1  leave HALT.
pc  out  32  current fetch address.
pc_plus4  out  32  pc + 4, combinational; the link value for jal/jalr.
pc_valid  out  1  pc is a real fetch this cycle.
epc  out  32  PC of the faulting instruction.
addr_err  out  1  one-cycle pulse: misaligned jr target.
state  out  2  FSM state: BOOT=0, RUN=1, STALL=2, HALT=3.

Behaviour:
- Reset (async): pc=RESET_VECTOR, epc=0, addr_err=0, state=BOOT, pc_valid=0.
- Asserting reset mid-operation discards everything in flight and returns to the reset values.
- Arithmetic:
  - pc_plus4 = pc + 32'd4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
  - branch_tgt = pc_plus4 + (branch_offset << 2), modulo 2^32; the shifted-out bits are dropped.
  - jump_tgt = {pc_plus4[31:28], jump_index, 2'b00}.
- pc_valid = 1 in RUN only; 0 in BOOT, STALL and HALT.
- FSM:
  - BOOT: always goes to RUN next cycle; pc stays RESET_VECTOR. All inputs are ignored. The first valid fetch is RESET_VECTOR, one cycle after reset deasserts.
  - RUN: pc updates every cycle by the priority list below.
    - exception → pc=EXC_VECTOR, epc=pc, stay in RUN.
    - else halt_req → HALT, pc held.
    - else stall → STALL, pc held.
    - else the next-PC mux loads pc.
  - STALL: pc held; stall, branch_taken, jump and jr are ignored. exception has the same effect as in RUN and goes to RUN. Else stall=0 → RUN. halt_req while in STALL is ignored.
  - HALT: pc held. resume=1 → RUN; no fetch happens in the resume cycle, so the next fetch is the held pc. exception, stall and the control inputs are ignored.
- Next-PC priority in RUN (no stall, no halt_req):
  1. jr with jr_target[1:0]!=0: pc=EXC_VECTOR, epc=pc, addr_err=1 for exactly that cycle.
  2. jr (aligned): pc=jr_target.
  3. jump: pc=jump_tgt.
  4. branch_taken: pc=branch_tgt.
  5. Otherwise: pc=pc_plus4.
- Simultaneous events:
  - exception beats all other inputs.
  - halt_req beats stall.
  - Among jr/jump/branch_taken, the priority order above applies; the lower-priority requests are dropped.
- addr_err is registered and is 0 in every cycle except the misaligned-jr cycle.
- epc changes only on an exception or a misaligned jr.

Decomposition:
- Shared package pc_pkg: state encoding constants BOOT/RUN/STALL/HALT; the default vector values; the constant PC_INC=4.
- One natural sub-module: the team's 32-bit two-input adder. Instantiate it twice: pc+4, and pc_plus4+(offset<<2).
- The FSM and next-PC mux live in pc_sequencer.

Test Plan:
- Reset then idle inputs → BOOT for 1 cycle with pc=0, pc_valid=0; then RUN; pc goes 0x0, 0x4, 0x8, 0xC on successive cycles.
- pc=0x0000_0010, branch_taken=1, branch_offset=0xFFFF_FFFE → next pc=0x0000_000C. Same pc with jump=1, jump_index=0x0000_040 asserted alongside branch_taken → pc=0x0000_0100 (jump wins).
- pc=0x0000_0020, jr=1, jr_target=0x0040_0002 → pc=0x8000_0180, epc=0x0000_0020, addr_err=1 for one cycle. With jr_target=0x0040_0000 → pc=0x0040_0000, addr_err=0.
- RUN at pc=0x40, stall=1 for 3 cycles → pc=0x40, pc_valid=0, state=STALL. Raise exception in the 2nd stall cycle → pc=0x8000_0180, epc=0x40, state=RUN.
- halt_req=1 with stall=1 at pc=0x80 → HALT, pc=0x80. Pulse resume → RUN; next fetch is pc=0x80, the one after 0x84.
- pc=0xFFFF_FFFC sequential → pc=0x0000_0000. Assert reset asynchronously mid-STALL → pc=RESET_VECTOR and state=BOOT immediately, without waiting for a clock edge.
